// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier: one conditional ripple-carry add
// and one right shift per cycle, giving a 2*WIDTH-bit product after WIDTH steps.
module seq_shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_r, state_s;
   logic [WIDTH-1:0]     m_r, q_r, acc_r;
   logic                 c_r;
   logic [CW-1:0]        count_r;
   logic                 busy_r, done_r;
   logic [2*WIDTH-1:0]   p_r;

   logic [WIDTH:0]       sum_s;
   logic                 add_c_s;
   logic [WIDTH-1:0]     add_acc_s;
   logic [WIDTH-1:0]     acc_shift_s, q_shift_s;

   // Bit-serial carry chain; equivalent to four_bit_RCA with Cin=0 when WIDTH=4.
   function automatic logic [WIDTH:0] rca_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             cin);
      logic             c;
      logic [WIDTH-1:0] s;
      c = cin;
      s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      return {c, s};
   endfunction

   // One multiply step: conditional add, then shift {C,acc,Q} right by one.
   always_comb begin
      sum_s = rca_add(acc_r, m_r, 1'b0);
      if (q_r[0]) begin
         add_c_s   = sum_s[WIDTH];
         add_acc_s = sum_s[WIDTH-1:0];
      end else begin
         add_c_s   = 1'b0;
         add_acc_s = acc_r;
      end
      acc_shift_s = {add_c_s, add_acc_s[WIDTH-1:1]};
      q_shift_s   = {add_acc_s[0], q_r[WIDTH-1:1]};
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (count_r == LAST_STEP) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         m_r     <= '0;
         q_r     <= '0;
         acc_r   <= '0;
         c_r     <= 1'b0;
         count_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         p_r     <= '0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == RUN);
         done_r  <= (state_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  m_r     <= A;
                  q_r     <= B;
                  acc_r   <= '0;
                  c_r     <= 1'b0;
                  count_r <= '0;
               end
            end
            RUN: begin
               acc_r   <= acc_shift_s;
               q_r     <= q_shift_s;
               c_r     <= 1'b0;
               count_r <= count_r + CW'(1);
               // The product is the post-shift value of the final step.
               if (count_r == LAST_STEP) begin
                  p_r <= {acc_shift_s, q_shift_s};
               end
            end
            default: begin
               c_r <= c_r;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign P    = p_r;

endmodule
